// File: rtl/whack_pkg.sv
// Shared types and BCD digit arithmetic for the whack-a-mole score/timer block.
// Digit helpers return {carry_or_borrow, digit} so callers can chain digits.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] MAX_BCD_SCORE = 8'h99;

  function automatic logic [4:0] bcd_inc(input bcd_t d);
    logic [4:0] r;
    if (d >= 4'd9) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [4:0] bcd_dec(input bcd_t d);
    logic [4:0] r;
    if (d == 4'd0) begin
      r = {1'b1, 4'd9};
    end else begin
      r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a one-cycle pulse on entry to the active level.
// The pulse is combinational from the synchronised flops so the consumer acts on the 3rd edge.
module sync_edge_det #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit RST_VAL    = ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      hist_p2 <= RST_VAL;
    end else begin
      sync_p0 <= async_in;
      // stage p1: metastability settles here
      sync_p1 <= sync_p0;
      // stage p2: previous level for edge detection
      hist_p2 <= sync_p1;
    end
  end

  assign pulse = ACTIVE_LOW ? (~sync_p1 & hist_p2) : (sync_p1 & ~hist_p2);

endmodule

// File: rtl/whack_score_timer.sv
// Game session controller: start arming, BCD seconds countdown and saturating BCD score.
// All outputs are registered and feed the 7-segment display driver.
module whack_score_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int GAME_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_n,
  input  logic       add_point,
  output logic       working_sig,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       sec_tick,
  output logic       game_over
);

  import whack_pkg::*;

  localparam int              PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam bcd_t            GAME_TENS = 4'(GAME_SEC / 10);
  localparam bcd_t            GAME_ONES = 4'(GAME_SEC % 10);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("whack_score_timer: TICK_DIV must be at least 2");
  end
  if (GAME_SEC < 1 || GAME_SEC > 99) begin : g_bad_game_sec
    $error("whack_score_timer: GAME_SEC must be within 1..99");
  end

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic             start_evt;
  logic             hit_evt;

  sync_edge_det #(
    .ACTIVE_LOW (1'b1)
  ) u_start_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (start_n),
    .pulse    (start_evt)
  );

  sync_edge_det #(
    .ACTIVE_LOW (1'b0)
  ) u_hit_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (add_point),
    .pulse    (hit_evt)
  );

  logic [4:0] score_ones_inc;
  logic [4:0] score_tens_inc;
  logic [4:0] time_ones_dec;
  logic [4:0] time_tens_dec;
  logic       score_at_max;
  logic       last_sec;
  logic       pre_wrap;

  always_comb begin
    score_ones_inc = bcd_inc(score_ones);
    score_tens_inc = bcd_inc(score_tens);
    time_ones_dec  = bcd_dec(time_ones);
    time_tens_dec  = bcd_dec(time_tens);
    // both digits carrying out means the score already reads 99
    score_at_max   = score_ones_inc[4] & score_tens_inc[4];
    // a tens borrow means the tens digit is zero, so 01 is the last second
    last_sec       = time_tens_dec[4] & (time_ones == 4'd1);
    pre_wrap       = (prescaler == PRE_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prescaler   <= '0;
      working_sig <= 1'b0;
      sec_tick    <= 1'b0;
      game_over   <= 1'b0;
      score_tens  <= 4'd0;
      score_ones  <= 4'd0;
      time_tens   <= 4'd0;
      time_ones   <= 4'd0;
    end else begin
      sec_tick  <= 1'b0;
      game_over <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_evt) begin
            state       <= RUN;
            working_sig <= 1'b1;
            prescaler   <= '0;
            score_tens  <= 4'd0;
            score_ones  <= 4'd0;
            time_tens   <= GAME_TENS;
            time_ones   <= GAME_ONES;
          end
        end
        RUN: begin
          if (hit_evt && !score_at_max) begin
            score_ones <= score_ones_inc[3:0];
            if (score_ones_inc[4]) begin
              score_tens <= score_tens_inc[3:0];
            end
          end
          if (pre_wrap) begin
            prescaler <= '0;
            sec_tick  <= 1'b1;
            time_ones <= time_ones_dec[3:0];
            if (time_ones_dec[4]) begin
              time_tens <= time_tens_dec[3:0];
            end
            if (last_sec) begin
              state       <= DONE;
              working_sig <= 1'b0;
              game_over   <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          working_sig <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_whack_score_timer.sv
// Directed bench for whack_score_timer: a short 3 s session instance and a 99 s instance
// for score saturation and time borrow, with expected values queued at stimulus time.
module tb_whack_score_timer;

  import whack_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n, add_point;
  logic       start_n_b, add_point_b;

  logic       working_sig, sec_tick, game_over;
  logic [3:0] score_tens, score_ones, time_tens, time_ones;
  logic       working_sig_b, sec_tick_b, game_over_b;
  logic [3:0] score_tens_b, score_ones_b, time_tens_b, time_ones_b;

  always #5 clk = ~clk;

  whack_score_timer #(.TICK_DIV(10), .GAME_SEC(3)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_n     (start_n),
    .add_point   (add_point),
    .working_sig (working_sig),
    .score_tens  (score_tens),
    .score_ones  (score_ones),
    .time_tens   (time_tens),
    .time_ones   (time_ones),
    .sec_tick    (sec_tick),
    .game_over   (game_over)
  );

  whack_score_timer #(.TICK_DIV(10), .GAME_SEC(99)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_n     (start_n_b),
    .add_point   (add_point_b),
    .working_sig (working_sig_b),
    .score_tens  (score_tens_b),
    .score_ones  (score_ones_b),
    .time_tens   (time_tens_b),
    .time_ones   (time_ones_b),
    .sec_tick    (sec_tick_b),
    .game_over   (game_over_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int entry = 0;
  int go_count = 0;
  int exp_score_b = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (game_over === 1'b1) go_count <= go_count + 1;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_to(input int rel);
    while ((cyc - entry) < rel) @(negedge clk);
  endtask

  task automatic hit_b();
    add_point_b = 1'b1;
    step(2);
    add_point_b = 1'b0;
    step(2);
    exp_score_b = (exp_score_b >= 99) ? 99 : exp_score_b + 1;
  endtask

  function automatic logic [7:0] flags_a();
    return {5'd0, working_sig, sec_tick, game_over};
  endfunction

  function automatic logic [7:0] flags_b();
    return {5'd0, working_sig_b, sec_tick_b, game_over_b};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_n = 1'b1;
    add_point = 1'b0;
    start_n_b = 1'b1;
    add_point_b = 1'b0;
    step(3);
    push("rst_flags", 8'h00);  check(flags_a());
    push("rst_score", 8'h00);  check({score_tens, score_ones});
    push("rst_time", 8'h00);   check({time_tens, time_ones});

    rst_n = 1'b1;
    step(20);
    push("idle_flags", 8'h00); check(flags_a());
    push("idle_time", 8'h00);  check({time_tens, time_ones});

    add_point = 1'b1;
    step(2);
    add_point = 1'b0;
    step(4);
    push("idle_hit_score", 8'h00); check({score_tens, score_ones});

    // session 1: countdown, start ignored in RUN, hit on the final tick
    start_n = 1'b0;
    step(2);
    push("start_latency_2", 8'h00); check(flags_a());
    step(1);
    entry = cyc;
    start_n = 1'b1;
    push("start_flags", 8'h04); check(flags_a());
    push("start_time", 8'h03);  check({time_tens, time_ones});
    push("start_score", 8'h00); check({score_tens, score_ones});

    step_to(9);
    push("pre_tick_flags", 8'h04); check(flags_a());
    push("pre_tick_time", 8'h03);  check({time_tens, time_ones});
    step_to(10);
    push("tick1_flags", 8'h06); check(flags_a());
    push("tick1_time", 8'h02);  check({time_tens, time_ones});
    step_to(11);
    push("tick1_end_flags", 8'h04); check(flags_a());

    start_n = 1'b0;
    step_to(13);
    start_n = 1'b1;
    step_to(19);
    push("run_start_ignored_time", 8'h02); check({time_tens, time_ones});
    step_to(20);
    push("tick2_flags", 8'h06); check(flags_a());
    push("tick2_time", 8'h01);  check({time_tens, time_ones});

    step_to(21);
    add_point = 1'b1;
    step_to(23);
    add_point = 1'b0;
    step_to(25);
    push("hit1_score", 8'h01); check({score_tens, score_ones});

    step_to(27);
    add_point = 1'b1;
    step_to(29);
    add_point = 1'b0;
    push("pre_final_flags", 8'h04); check(flags_a());
    push("pre_final_time", 8'h01);  check({time_tens, time_ones});
    step_to(30);
    push("final_flags", 8'h03); check(flags_a());
    push("final_time", 8'h00);  check({time_tens, time_ones});
    push("final_hit_score", 8'h02); check({score_tens, score_ones});
    step_to(31);
    push("done_flags", 8'h00); check(flags_a());

    add_point = 1'b1;
    step(2);
    add_point = 1'b0;
    step(4);
    push("done_hit_score", 8'h02); check({score_tens, score_ones});
    push("done_time", 8'h00);      check({time_tens, time_ones});
    push("go_count_s1", 8'd1);     check(8'(go_count));

    // session 2: restart from DONE, then reset mid-run
    start_n = 1'b0;
    step(3);
    entry = cyc;
    start_n = 1'b1;
    push("restart_flags", 8'h04); check(flags_a());
    push("restart_time", 8'h03);  check({time_tens, time_ones});
    push("restart_score", 8'h00); check({score_tens, score_ones});
    for (int k = 0; k < 4; k++) begin
      add_point = 1'b1;
      step(2);
      add_point = 1'b0;
      step(2);
    end
    step_to(17);
    push("mid_time", 8'h02);  check({time_tens, time_ones});
    push("mid_score", 8'h04); check({score_tens, score_ones});

    rst_n = 1'b0;
    #1;
    push("async_rst_flags", 8'h00); check(flags_a());
    push("async_rst_score", 8'h00); check({score_tens, score_ones});
    push("async_rst_time", 8'h00);  check({time_tens, time_ones});
    step(5);
    rst_n = 1'b1;
    step(3);
    push("no_go_on_reset", 8'd1); check(8'(go_count));

    // session 3: clean session after reset, run to completion
    start_n = 1'b0;
    step(3);
    entry = cyc;
    start_n = 1'b1;
    push("clean_flags", 8'h04); check(flags_a());
    push("clean_time", 8'h03);  check({time_tens, time_ones});
    push("clean_score", 8'h00); check({score_tens, score_ones});
    step_to(31);
    push("clean_done_flags", 8'h00); check(flags_a());
    push("clean_done_time", 8'h00);  check({time_tens, time_ones});
    push("go_count_s3", 8'd2);       check(8'(go_count));

    // 99 s instance: held level, BCD carry, saturation, BCD borrow
    start_n_b = 1'b0;
    step(3);
    entry = cyc;
    start_n_b = 1'b1;
    push("b_start_flags", 8'h04); check(flags_b());
    push("b_start_time", 8'h99);  check({time_tens_b, time_ones_b});

    add_point_b = 1'b1;
    step(20);
    add_point_b = 1'b0;
    step(2);
    exp_score_b = 1;
    push("b_held_score", to_bcd(exp_score_b)); check({score_tens_b, score_ones_b});
    for (int k = 0; k < 5; k++) hit_b();
    push("b_score6", to_bcd(exp_score_b)); check({score_tens_b, score_ones_b});
    for (int k = 0; k < 3; k++) hit_b();
    push("b_score9", 8'h09); check({score_tens_b, score_ones_b});
    hit_b();
    push("b_carry10", 8'h10); check({score_tens_b, score_ones_b});
    for (int k = 0; k < 100; k++) hit_b();
    push("b_saturate", MAX_BCD_SCORE); check({score_tens_b, score_ones_b});
    push("b_model_sat", to_bcd(exp_score_b)); check({score_tens_b, score_ones_b});

    step_to(899);
    push("b_time10", 8'h10);      check({time_tens_b, time_ones_b});
    push("b_time10_flags", 8'h04); check(flags_b());
    step_to(900);
    push("b_borrow09", 8'h09);    check({time_tens_b, time_ones_b});
    push("b_borrow_flags", 8'h06); check(flags_b());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/whack_score_timer.md
Name: whack_score_timer

Overview:
- Downstream stage of the LED/button game logic. Consumes its one-bit `add_point` hit indication and produces the `working_sig` game-enable it depends on.
- Runs the game session: start-button arming, countdown in seconds, and a 2-digit BCD score. All outputs feed the 7-segment display driver.
- Single clock domain (`clk`). `add_point` and `start_n` are treated as asynchronous to `clk`.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per game second (≥2).
- GAME_SEC, 30, session length in seconds (1..99).
- Both are elaborated as constants; an out-of-range value is an elaboration error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_n  in  1  start button, active-low, debounced externally, asynchronous.
- add_point  in  1  hit indication from LED control, level, may stay high for several cycles, asynchronous.
- working_sig  out  1  1 while a session is running.
- score_tens  out  4  BCD tens digit of the score.
- score_ones  out  4  BCD ones digit of the score.
- time_tens  out  4  BCD tens digit of seconds remaining.
- time_ones  out  4  BCD ones digit of seconds remaining.
- sec_tick  out  1  one-cycle pulse per game second while running.
- game_over  out  1  one-cycle pulse when the countdown expires.

Behaviour:
- Reset is asynchronous on rst_n low:
  - state = IDLE;
  - all outputs 0, all BCD digits 0;
  - prescaler 0;
  - synchroniser flops 0 for add_point; synchroniser flops 1 for start_n (idle level).
- Input conditioning:
  - each async input passes through a 2-flop synchroniser, then a rising-edge detector on the active level;
  - start event = falling edge of start_n; hit event = rising edge of add_point;
  - an event is seen by the FSM on the 3rd rising clk edge after the input transition, and outputs update on that same edge;
  - a held level produces exactly one event.
- State IDLE:
  - working_sig = 0; digits hold their values (0 after reset);
  - on a start event: score ← 00, time ← GAME_SEC in BCD, prescaler ← 0, go to RUN.
- State RUN:
  - working_sig = 1, registered, asserted on the same edge RUN is entered;
  - the prescaler counts 0..TICK_DIV-1 and wraps;
  - at wrap, sec_tick = 1 for one cycle and time decrements in BCD: ones 0 → 9 with a tens borrow;
  - when the decrement takes time 01 → 00: go to DONE, game_over = 1 for one cycle, working_sig ← 0 on that same edge;
  - first sec_tick occurs TICK_DIV cycles after entry.
- Score counting (RUN only):
  - each hit event increments score in BCD: 9 → 0 on ones with a tens carry;
  - the score saturates at 99, with no wrap.
- State DONE:
  - working_sig = 0; score and time (00) are held for display; hit events are ignored;
  - a start event restarts exactly as from IDLE.
- Simultaneous events:
  - a hit event on the same cycle as the final tick is counted;
  - a start event during RUN is ignored and does not restart the session;
  - a hit event in IDLE or DONE is ignored.
- Reset mid-session: immediate return to IDLE with all values cleared; no game_over pulse is generated.
- sec_tick and game_over are never high outside RUN→DONE transitions. game_over fires exactly once per session.

Decomposition:
- Package `whack_pkg`:
  - state enum {IDLE, RUN, DONE};
  - BCD digit typedef (4 bits);
  - BCD increment-with-carry and decrement-with-borrow functions;
  - constant MAX_BCD_SCORE = 8'h99.
- Sub-module `sync_edge_det`, instantiated twice:
  - 2-flop synchroniser plus rising-edge pulse;
  - parameter for active-low input and reset level.

Test Plan (TICK_DIV=10, GAME_SEC=3):
- Reset held, then released with no input → all outputs 0; state stays IDLE; working_sig 0 indefinitely.
- start_n pulse low → working_sig = 1 on the 3rd edge with time = 03. sec_tick pulses every 10 cycles. Time reads 02 then 01. The third tick gives time = 00, game_over pulses once, and working_sig = 0 on that same edge.
- In RUN, add_point held high for 20 cycles, then 5 separate pulses → score = 06. A further 100 pulses (with GAME_SEC raised to 99) → score saturates at 99.
- Score at 09 plus one hit → score = 10, confirming the BCD carry. Time at 10 plus one tick → 09, confirming the BCD borrow.
- Hit event coincident with the final tick → counted, final score +1. Hits in DONE → score unchanged. start_n in RUN → no restart, countdown continues.
- rst_n asserted mid-RUN at time 02 and score 04 → all outputs 0 immediately; no game_over. A subsequent start event begins a clean session with time 03 and score 00.
